uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Serial receive front end for the core's UART read port. Decodes 8N1 frames from the `rxd` pin, buffers completed bytes in a FIFO, and presents them to the core as `q` / `empty` / `rdreq`, the same handshake the core already uses for `uart_in` / `uart_empty` / `uart_rdreq`. Runs entirely in the core clock domain, so the core needs no clock-crossing FIFO on the receive side.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 434 — `clk` cycles per bit (50 MHz / 115200 baud); legal range ≥ 4.
- `DEPTH_LOG2`, default 4 — FIFO holds 2^DEPTH_LOG2 bytes.

Ports:
- `clk`  in  1 — single clock; all logic is on the rising edge.
- `rst`  in  1 — synchronous, active-high reset.
- `rxd`  in  1 — asynchronous serial line; idles high.
- `rdreq`  in  1 — pops the head entry when `empty`=0; ignored when `empty`=1.
- `q`  out  8 — head byte; valid whenever `empty`=0 (show-ahead).
- `empty`  out  1 — FIFO holds 0 entries.
- `full`  out  1 — FIFO holds 2^DEPTH_LOG2 entries.
- `frame_err`  out  1 — one-cycle pulse: stop bit sampled low.
- `overrun`  out  1 — one-cycle pulse: byte dropped because the FIFO was full.

## Operation
- `rxd` passes through a 2-flop synchronizer to give `rxs`. All decoding uses `rxs`.
- Receiver FSM:
  - IDLE: on `rxs`=0, load the bit counter with CLKS_PER_BIT/2−1 and go to START.
  - START: when the counter expires, sample `rxs`. If 0, go to DATA with bit index 0. If 1 (glitch), go to IDLE; nothing is pushed.
  - DATA: every CLKS_PER_BIT cycles, sample into the shift register LSB-first. After bit 7, go to STOP.
  - STOP: after CLKS_PER_BIT cycles, sample `rxs`.
    - If 1: push the byte and go to IDLE.
    - If 0: pulse `frame_err`, discard the byte, and go to BREAK.
  - BREAK: wait for `rxs`=1, then go to IDLE. A low line is never treated as a new start bit here.
- FIFO: 2^DEPTH_LOG2 × 8 memory, with read/write pointers of DEPTH_LOG2 bits that wrap modulo depth, and a DEPTH_LOG2+1-bit count.
  - Push is accepted if count < depth, or if a pop happens in the same cycle.
  - Otherwise the byte is dropped, `overrun` pulses, and FIFO contents are unchanged.
  - Simultaneous push and pop: both happen and count is unchanged. When count=0, a push with `rdreq`=1 is a push only.
  - `rdreq` while `empty`=1 is a no-op: no pointer movement and no error.
- Reset mid-frame aborts the frame. The FSM goes to IDLE and the FIFO is cleared. A partially received frame is never pushed. A frame whose start edge occurs while `rst`=1 is lost.

## Timing
- Reset values:
  - `empty`=1, `full`=0, `frame_err`=0, `overrun`=0.
  - `q`=8'h00; don't-care while `empty`=1, but must not be X.
  - FSM in IDLE, pointers and count 0.
- Input latency: 2 cycles from `rxd` to `rxs`.
- Sampling points: the start bit is checked CLKS_PER_BIT/2 cycles after `rxs` falls. Data bit n is sampled (n+1)·CLKS_PER_BIT cycles after that. The stop bit is sampled 9·CLKS_PER_BIT cycles after that.
- Push happens in the cycle after the stop sample. `empty` falls and `q` is valid one cycle after the push.
- The FSM is back in IDLE by mid-stop-bit, so back-to-back frames with a single stop bit are received without loss.
- `rdreq` sampled high with `empty`=0: the pointer advances at that edge. The next `q` or `empty`=1 is visible in the following cycle.
- `full` and `empty` are registered and reflect count after the same edge that updates count.
- `frame_err` and `overrun` are high for exactly one cycle per event.

## Test plan
Use CLKS_PER_BIT=16 and DEPTH_LOG2=4 in simulation.
- Single frame 8'hA5 (bits LSB-first, stop=1) → `empty` falls about 152 cycles after the start edge, `q`=8'hA5. One `rdreq` pulse → `empty`=1 on the next cycle.
- `rxd` low for 4 cycles, then high → no push, `frame_err`=0, and a following 8'h3C frame is received correctly.
- Frame 8'h3C with stop bit 0, line held low for 40 cycles, then high → one `frame_err` pulse, `empty` stays 1, no spurious frame; the next frame 8'h11 is received.
- 17 back-to-back frames 8'h00..8'h10 with no reads → `full`=1 after the 16th, `overrun` pulses once on the 17th. Draining returns 8'h00..8'h0F in order, then `empty`=1.
- FIFO full, `rdreq`=1 in the push cycle of a new byte 8'h77 → no `overrun`, count stays 16, and 8'h77 is the last byte drained.
- `rst` asserted for 1 cycle midway through a data bit of 8'hFF → `empty`=1 and nothing pushed. A frame 8'h5A starting 20 cycles after reset is received correctly.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a show-ahead byte FIFO, all in the core clock domain.
// Completed bytes are pushed one cycle after the stop-bit sample; framing and overflow events pulse for one cycle.
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DEPTH_LOG2   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  input  logic       rdreq,
  output logic [7:0] q,
  output logic       empty,
  output logic       full,
  output logic       frame_err,
  output logic       overrun
);

  localparam int CW    = $clog2(CLKS_PER_BIT);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  localparam logic [CW-1:0]         HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0]         FULL_LOAD = CW'(CLKS_PER_BIT - 1);
  localparam logic [DEPTH_LOG2:0]   DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } rx_state_e;

  // ---------------------------------------------------------------------------
  // Input synchronizer
  // ---------------------------------------------------------------------------
  logic rx_meta;
  logic rxs;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rxd;
      rxs     <= rx_meta;
    end
  end

  // ---------------------------------------------------------------------------
  // Receiver FSM
  // ---------------------------------------------------------------------------
  rx_state_e     state, state_n;
  logic [CW-1:0] bit_cnt, bit_cnt_n;
  logic [2:0]    bit_idx, bit_idx_n;
  logic [7:0]    shift, shift_n;
  logic          push_req, push_req_n;
  logic          frame_err_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      bit_cnt   <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      push_req  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      bit_cnt   <= bit_cnt_n;
      bit_idx   <= bit_idx_n;
      shift     <= shift_n;
      push_req  <= push_req_n;
      frame_err <= frame_err_n;
    end
  end

  // NOTE: every output of this block is given a default before the case
  // statement, so no path can leave a signal unassigned and infer a latch.
  always_comb begin
    state_n     = state;
    bit_cnt_n   = (bit_cnt != '0) ? bit_cnt - 1'b1 : bit_cnt;
    bit_idx_n   = bit_idx;
    shift_n     = shift;
    push_req_n  = 1'b0;
    frame_err_n = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (!rxs) begin
          state_n   = S_START;
          bit_cnt_n = HALF_LOAD;
        end
      end

      S_START: begin
        if (bit_cnt == '0) begin
          if (!rxs) begin
            state_n   = S_DATA;
            bit_cnt_n = FULL_LOAD;
            bit_idx_n = '0;
          end else begin
            state_n   = S_IDLE;
          end
        end
      end

      S_DATA: begin
        if (bit_cnt == '0) begin
          shift_n   = {rxs, shift[7:1]};
          bit_cnt_n = FULL_LOAD;
          if (bit_idx == 3'd7) begin
            state_n   = S_STOP;
          end else begin
            bit_idx_n = bit_idx + 3'd1;
          end
        end
      end

      S_STOP: begin
        // Leaving at mid-stop-bit lets the next start edge be caught on time.
        if (bit_cnt == '0) begin
          if (rxs) begin
            push_req_n  = 1'b1;
            state_n     = S_IDLE;
          end else begin
            frame_err_n = 1'b1;
            state_n     = S_BREAK;
          end
        end
      end

      S_BREAK: begin
        if (rxs) begin
          state_n = S_IDLE;
        end
      end

      default: state_n = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   count;
  logic [DEPTH_LOG2:0]   count_n;
  logic                  rd_en;
  logic                  wr_en;

  assign rd_en = rdreq && !empty;
  assign wr_en = push_req && ((count < DEPTH_CNT) || rd_en);

  always_comb begin
    count_n = count;
    unique case ({wr_en, rd_en})
      2'b10:   count_n = count + 1'b1;
      2'b01:   count_n = count - 1'b1;
      default: count_n = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      empty   <= 1'b1;
      full    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      count   <= count_n;
      empty   <= (count_n == '0);
      full    <= (count_n == DEPTH_CNT);
      overrun <= push_req && !wr_en;
    end
  end

  // NOTE: the storage array has no reset; stale contents are never visible
  // because q is forced to zero while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= shift;
  end

  assign q = empty ? 8'h00 : mem[rd_ptr];

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: serial frames are driven on rxd and the
// popped bytes and event pulses are compared against a queue-based model.
module tb_uart_rx_fifo;

  localparam int CPB   = 16;
  localparam int DL2   = 4;
  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       rxd;
  logic       rdreq;
  logic [7:0] q;
  logic       empty;
  logic       full;
  logic       frame_err;
  logic       overrun;

  always #5 clk = ~clk;

  uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DEPTH_LOG2(DL2)) dut (
    .clk       (clk),
    .rst       (rst),
    .rxd       (rxd),
    .rdreq     (rdreq),
    .q         (q),
    .empty     (empty),
    .full      (full),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  int checks = 0;
  int errors = 0;
  int ferr_cycles = 0;
  int ovr_cycles  = 0;
  int exp_ovr     = 0;
  logic [7:0] model_q[$];

  // Each event is a one-cycle pulse, so high cycles equal event count.
  always @(negedge clk) begin
    if (frame_err === 1'b1) ferr_cycles++;
    if (overrun === 1'b1)   ovr_cycles++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives one 8N1 frame starting at the current negedge; rxd is left at stop_bit.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    rxd = 1'b0;
    idle(CPB);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      idle(CPB);
    end
    rxd = stop_bit;
    idle(CPB);
  endtask

  function automatic void model_push(input logic [7:0] b);
    if (model_q.size() < DEPTH) model_q.push_back(b);
    else exp_ovr++;
  endfunction

  task automatic pop_byte(output logic [7:0] b, output logic was_empty);
    b         = q;
    was_empty = empty;
    rdreq     = 1'b1;
    idle(1);
    rdreq     = 1'b0;
  endtask

  task automatic drain_model(input string name);
    logic [7:0] b;
    logic       e;
    logic [7:0] exp_b;
    int         n;
    n = model_q.size();
    for (int i = 0; i < n; i++) begin
      exp_b = model_q.pop_front();
      pop_byte(b, e);
      checks++;
      if (e !== 1'b0 || b !== exp_b) begin
        errors++;
        $display("FAIL %s pop %0d: got q=%h empty=%b expected q=%h empty=0", name, i, b, e, exp_b);
      end
    end
    checks++;
    if (empty !== 1'b1) begin
      errors++;
      $display("FAIL %s drained: got empty=%b expected 1", name, empty);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; rxd = 1'b1; rdreq = 1'b0;
    idle(4);
    rst = 1'b0;
    idle(1);
    checks++;
    if ({empty, full, frame_err, overrun} !== 4'b1000 || q !== 8'h00) begin
      errors++;
      $display("FAIL reset: got empty=%b full=%b ferr=%b ovr=%b q=%h expected 1 0 0 0 00",
               empty, full, frame_err, overrun, q);
    end
  endtask

  task automatic test_single;
    int lat;
    logic [7:0] b;
    logic e;
    lat = 0;
    fork
      send_frame(8'hA5, 1'b1);
      begin
        while (empty === 1'b1 && lat < 400) begin
          idle(1);
          lat++;
        end
      end
    join
    rxd = 1'b1;
    checks++;
    if (lat < 148 || lat > 160) begin
      errors++;
      $display("FAIL single latency: got %0d cycles expected about 152", lat);
    end
    pop_byte(b, e);
    checks++;
    if (b !== 8'hA5 || e !== 1'b0) begin
      errors++;
      $display("FAIL single data: got q=%h empty=%b expected q=a5 empty=0", b, e);
    end
    checks++;
    if (empty !== 1'b1) begin
      errors++;
      $display("FAIL single pop: got empty=%b expected 1", empty);
    end
  endtask

  task automatic test_glitch;
    int f0;
    f0 = ferr_cycles;
    rxd = 1'b0;
    idle(4);
    rxd = 1'b1;
    idle(40);
    checks++;
    if (empty !== 1'b1 || ferr_cycles != f0) begin
      errors++;
      $display("FAIL glitch: got empty=%b ferr=%0d expected empty=1 ferr=0", empty, ferr_cycles - f0);
    end
    send_frame(8'h3C, 1'b1);
    model_push(8'h3C);
    idle(3);
    drain_model("glitch_follow");
  endtask

  task automatic test_frame_err;
    int f0;
    f0 = ferr_cycles;
    send_frame(8'h3C, 1'b0);
    idle(40);
    rxd = 1'b1;
    idle(20);
    checks++;
    if (ferr_cycles - f0 != 1 || empty !== 1'b1) begin
      errors++;
      $display("FAIL frame_err: got pulses=%0d empty=%b expected pulses=1 empty=1", ferr_cycles - f0, empty);
    end
    send_frame(8'h11, 1'b1);
    model_push(8'h11);
    idle(3);
    drain_model("after_break");
  endtask

  task automatic test_full;
    int o0;
    o0 = ovr_cycles;
    exp_ovr = 0;
    for (int i = 0; i < 16; i++) begin
      send_frame(8'(i), 1'b1);
      model_push(8'(i));
    end
    checks++;
    if (full !== 1'b1 || ovr_cycles != o0) begin
      errors++;
      $display("FAIL full after 16: got full=%b ovr=%0d expected full=1 ovr=0", full, ovr_cycles - o0);
    end
    send_frame(8'h10, 1'b1);
    model_push(8'h10);
    idle(2);
    checks++;
    if (ovr_cycles - o0 != exp_ovr || full !== 1'b1) begin
      errors++;
      $display("FAIL overrun: got pulses=%0d full=%b expected pulses=%0d full=1", ovr_cycles - o0, full, exp_ovr);
    end
    drain_model("full_drain");
  endtask

  task automatic test_full_pop;
    int o0;
    logic [7:0] b;
    for (int i = 0; i < 16; i++) begin
      b = 8'($urandom);
      send_frame(b, 1'b1);
      model_push(b);
    end
    idle(2);
    o0 = ovr_cycles;
    checks++;
    if (full !== 1'b1) begin
      errors++;
      $display("FAIL prefill: got full=%b expected 1", full);
    end
    // The write edge is the 156th rising edge after rxd falls.
    fork
      send_frame(8'h77, 1'b1);
      begin
        idle(155);
        rdreq = 1'b1;
        idle(1);
        rdreq = 1'b0;
      end
    join
    void'(model_q.pop_front());
    model_push(8'h77);
    idle(2);
    checks++;
    if (ovr_cycles != o0 || full !== 1'b1) begin
      errors++;
      $display("FAIL push+pop at full: got ovr=%0d full=%b expected ovr=0 full=1", ovr_cycles - o0, full);
    end
    drain_model("full_pop_drain");
  endtask

  task automatic test_reset_midframe;
    logic [7:0] b;
    logic e;
    send_frame(8'h42, 1'b1);
    model_push(8'h42);
    rxd = 1'b0;
    idle(CPB);
    rxd = 1'b1;
    idle(3 * CPB + CPB / 2);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    model_q.delete();
    checks++;
    if (empty !== 1'b1 || full !== 1'b0 || q !== 8'h00) begin
      errors++;
      $display("FAIL reset midframe: got empty=%b full=%b q=%h expected 1 0 00", empty, full, q);
    end
    idle(120);
    checks++;
    if (empty !== 1'b1) begin
      errors++;
      $display("FAIL aborted frame pushed: got empty=%b expected 1", empty);
    end
    idle(20);
    send_frame(8'h5A, 1'b1);
    idle(3);
    pop_byte(b, e);
    checks++;
    if (b !== 8'h5A || e !== 1'b0) begin
      errors++;
      $display("FAIL post-reset frame: got q=%h empty=%b expected 5a 0", b, e);
    end
    checks++;
    if (empty !== 1'b1) begin
      errors++;
      $display("FAIL post-reset pop: got empty=%b expected 1", empty);
    end
  endtask

  task automatic test_random;
    int n;
    int o0;
    logic [7:0] b;
    o0 = ovr_cycles;
    exp_ovr = 0;
    n = $urandom_range(8, 20);
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom);
      send_frame(b, 1'b1);
      model_push(b);
      idle($urandom_range(0, 12));
    end
    idle(3);
    checks++;
    if (ovr_cycles - o0 != exp_ovr) begin
      errors++;
      $display("FAIL random overrun: got %0d expected %0d", ovr_cycles - o0, exp_ovr);
    end
    checks++;
    if (full !== (model_q.size() == DEPTH)) begin
      errors++;
      $display("FAIL random full: got %b expected %b", full, model_q.size() == DEPTH);
    end
    drain_model("random");
  endtask

  initial begin
    rst = 1'b1; rxd = 1'b1; rdreq = 1'b0;
    @(negedge clk);
    test_reset();
    test_single();
    test_glitch();
    test_frame_err();
    test_full();
    test_full_pop();
    test_reset_midframe();
    test_random();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
